prf_multiport_rdy: RTL and testbench
====================================

Name: prf_multiport_rdy

Overview:
- Parametrised physical register file for the OoO core.
- Generalises the current 2-read/2-write file to NRD read ports, NWR write ports and NALLOC allocation ports.
- Adds a per-register ready (valid) scoreboard bit, same-cycle write-to-read bypass and registered write-conflict detection.
- Sits between rename/dispatch (allocation, operand reads) and the writeback/retire stage (writes).

Parameters:
- DATA_W, 32, data width of each register.
- PR_ADDR_W, 6, physical register address width.
- PR_NUM, 64, number of physical registers; must be ≤ 2^PR_ADDR_W.
- NRD, 4, number of read ports.
- NWR, 2, number of write ports.
- NALLOC, 2, number of allocation (ready-clear) ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*PR_ADDR_W  read addresses; port k occupies bits [k*PR_ADDR_W +: PR_ADDR_W].
- rd_data  out  NRD*DATA_W  read data, packed the same way.
- rd_rdy  out  NRD  ready bit of each read address.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*PR_ADDR_W  write addresses.
- wr_data  in  NWR*DATA_W  write data.
- alloc_en  in  NALLOC  per-port allocation enable; clears the ready bit.
- alloc_addr  in  NALLOC*PR_ADDR_W  registers being allocated to new producers.
- wr_conflict  out  1  registered pulse: two or more enabled write ports targeted the same nonzero address in the previous cycle.
- rdy_count  out  PR_ADDR_W+1  registered count of registers with ready=1.

Behaviour:
- Reset (asynchronous, rstn=0):
  - All registers = 0 and all ready bits = 1.
  - wr_conflict = 0; rdy_count = PR_NUM.
  - Deassertion is taken synchronously by the next clock edge.
- Register 0:
  - Writes and allocs to address 0 are ignored.
  - Reads of address 0 return 0 with rd_rdy = 1, regardless of bypass.
- Write (edge):
  - For each enabled port, reg[wr_addr] <= wr_data and ready[wr_addr] <= 1.
  - Same-address collision: the highest-index port wins data; wr_conflict = 1 the following cycle, for exactly one cycle unless the collision repeats.
- Alloc (edge):
  - For each enabled port, ready[alloc_addr] <= 0; data is unchanged.
  - Alloc and write to the same register in the same cycle: alloc wins (ready = 0, data = written value).
  - Duplicate alloc addresses are harmless.
- Reads:
  - Combinational; zero-latency view of the stored state plus bypass.
  - Bypass: if any enabled write port matches rd_addr (nonzero) this cycle, rd_data = that port's wr_data (highest index wins) and rd_rdy = 1.
  - Same-cycle alloc does not affect reads; it takes effect next cycle.
- rdy_count:
  - Updated every edge to the population count of the next-state ready vector.
  - Register 0 is always counted.
- Addresses ≥ PR_NUM: writes and allocs are ignored; reads return 0 with rd_rdy = 0.
- Reset mid-operation: in-flight writes and allocs are discarded; the full reset state applies immediately.
- Fully synchronous update; no blocking assignments to state.

Optional Feature:
- Macro PRF_BYPASS_EN.
- Defined: same-cycle write-to-read bypass as specified above.
- Undefined: rd_data and rd_rdy reflect stored state only. A value written at edge N is visible after edge N. This saves NRD×NWR comparators for timing-critical configurations.
- All other behaviour is identical.

Test Plan:
- Reset: hold rstn=0 for 2 cycles -> every rd_data = 0, rd_rdy = all 1, rdy_count = 64, wr_conflict = 0.
- Alloc then write: alloc p5 at cycle 1 -> rd_rdy for p5 = 0 from cycle 2, rdy_count = 63. Write p5 = 0x1234 at cycle 3 -> rd_rdy = 1 and rd_data = 0x1234 (same cycle with PRF_BYPASS_EN, next cycle without); rdy_count returns to 64.
- Write conflict: port0 writes p7 = 0xAAAA and port1 writes p7 = 0xBBBB in the same cycle -> p7 reads 0xBBBB afterwards; wr_conflict = 1 for exactly one cycle.
- p0 protection: alloc p0 and write p0 = 0xFFFF -> reads of p0 return 0 with rd_rdy = 1; rdy_count unchanged.
- Alloc/write race: alloc p9 and write p9 = 0x55 in the same cycle -> next cycle p9 has rd_rdy = 0 and rd_data = 0x55.
- Mid-run reset: assert rstn low asynchronously, between clock edges, while writes are pending -> outputs return to reset values without waiting for a clock edge; the pending write is not stored.

Source files
------------

// File: rtl/prf_multiport_rdy.sv
// Physical register file: NRD read / NWR write / NALLOC alloc ports, ready scoreboard,
// registered write-conflict flag and ready population count. Define PRF_BYPASS_EN for write-to-read bypass.
module prf_multiport_rdy #(
  parameter int DATA_W    = 32,
  parameter int PR_ADDR_W = 6,
  parameter int PR_NUM    = 64,
  parameter int NRD       = 4,
  parameter int NWR       = 2,
  parameter int NALLOC    = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NRD*PR_ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]       rd_data,
  output logic [NRD-1:0]              rd_rdy,
  input  logic [NWR-1:0]              wr_en,
  input  logic [NWR*PR_ADDR_W-1:0]    wr_addr,
  input  logic [NWR*DATA_W-1:0]       wr_data,
  input  logic [NALLOC-1:0]           alloc_en,
  input  logic [NALLOC*PR_ADDR_W-1:0] alloc_addr,
  output logic                        wr_conflict,
  output logic [PR_ADDR_W:0]          rdy_count
);

  logic [PR_NUM-1:0][DATA_W-1:0] w_store;
  logic [PR_NUM-1:0]             w_rdy_cur;
  logic [PR_NUM-1:0]             w_rdy_next;
  logic [PR_ADDR_W:0]            w_cnt_next;
  logic                          w_conf;
  logic                          r_wr_conflict;
  logic [PR_ADDR_W:0]            r_rdy_count;

  // Register 0 is hardwired: zero data, always ready.
  assign w_store[0]    = '0;
  assign w_rdy_cur[0]  = 1'b1;
  assign w_rdy_next[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < PR_NUM; gi++) begin : g_reg
      logic [DATA_W-1:0] r_data;
      logic              r_rdy;
      logic              w_hit;
      logic              w_alloc;
      logic [DATA_W-1:0] w_wdata;

      always_comb begin
        w_hit   = 1'b0;
        w_alloc = 1'b0;
        w_wdata = r_data;
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && wr_addr[p*PR_ADDR_W +: PR_ADDR_W] == PR_ADDR_W'(gi)) begin
            w_hit   = 1'b1;
            w_wdata = wr_data[p*DATA_W +: DATA_W];
          end
        end
        for (int a = 0; a < NALLOC; a++) begin
          if (alloc_en[a] && alloc_addr[a*PR_ADDR_W +: PR_ADDR_W] == PR_ADDR_W'(gi))
            w_alloc = 1'b1;
        end
      end

      // Allocation beats a same-cycle write for the ready bit; the data still lands.
      assign w_rdy_next[gi] = w_alloc ? 1'b0 : (w_hit ? 1'b1 : r_rdy);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_data <= '0;
          r_rdy  <= 1'b1;
        end else begin
          if (w_hit) r_data <= w_wdata;
          r_rdy <= w_rdy_next[gi];
        end
      end

      assign w_store[gi]   = r_data;
      assign w_rdy_cur[gi] = r_rdy;
    end
  endgenerate

  always_comb begin
    w_cnt_next = '0;
    for (int i = 0; i < PR_NUM; i++) w_cnt_next = w_cnt_next + (PR_ADDR_W+1)'(w_rdy_next[i]);
  end

  always_comb begin
    w_conf = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (wr_en[p] && wr_en[q] &&
            wr_addr[p*PR_ADDR_W +: PR_ADDR_W] == wr_addr[q*PR_ADDR_W +: PR_ADDR_W] &&
            wr_addr[p*PR_ADDR_W +: PR_ADDR_W] != '0)
          w_conf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_conflict <= 1'b0;
      r_rdy_count   <= (PR_ADDR_W+1)'(PR_NUM);
    end else begin
      r_wr_conflict <= w_conf;
      r_rdy_count   <= w_cnt_next;
    end
  end

  assign wr_conflict = r_wr_conflict;
  assign rdy_count   = r_rdy_count;

  genvar gr;
  generate
    for (gr = 0; gr < NRD; gr++) begin : g_rd
      logic [PR_ADDR_W-1:0] w_a;
      logic [DATA_W-1:0]    w_d;
      logic                 w_r;

      assign w_a = rd_addr[gr*PR_ADDR_W +: PR_ADDR_W];

      always_comb begin
        w_d = '0;
        w_r = 1'b0;
        if ({1'b0, w_a} < (PR_ADDR_W+1)'(PR_NUM)) begin
          w_d = w_store[w_a];
          w_r = w_rdy_cur[w_a];
`ifdef PRF_BYPASS_EN
          // Bypass is suppressed in reset so outputs show the reset state immediately.
          for (int p = 0; p < NWR; p++) begin
            if (rstn && wr_en[p] && w_a != '0 &&
                wr_addr[p*PR_ADDR_W +: PR_ADDR_W] == w_a) begin
              w_d = wr_data[p*DATA_W +: DATA_W];
              w_r = 1'b1;
            end
          end
`endif
        end
      end

      assign rd_data[gr*DATA_W +: DATA_W] = w_d;
      assign rd_rdy[gr]                   = w_r;
    end
  endgenerate

endmodule

// File: tb/tb_prf_multiport_rdy.sv
// Randomised + directed bench for prf_multiport_rdy against an array-based model of the register file.
module tb_prf_multiport_rdy;
  localparam int DW = 32, AW = 6, N = 64, NRD = 4, NWR = 2, NAL = 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*DW-1:0]    rd_data;
  logic [NRD-1:0]       rd_rdy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*DW-1:0]    wr_data;
  logic [NAL-1:0]       alloc_en;
  logic [NAL*AW-1:0]    alloc_addr;
  logic                 wr_conflict;
  logic [AW:0]          rdy_count;

  prf_multiport_rdy #(.DATA_W(DW), .PR_ADDR_W(AW), .PR_NUM(N), .NRD(NRD), .NWR(NWR), .NALLOC(NAL)) dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_rdy(rd_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .wr_conflict(wr_conflict), .rdy_count(rdy_count));

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_data [N];
  bit          m_rdy  [N];
  bit          m_conf;
  int          m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin m_data[i] = '0; m_rdy[i] = 1'b1; end
    m_conf = 1'b0;
    m_cnt  = N;
  endfunction

  function automatic void model_read(input int a, output logic [31:0] d, output bit r);
    d = m_data[a];
    r = m_rdy[a];
`ifdef PRF_BYPASS_EN
    if (a != 0)
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) begin d = wr_data[p*DW +: DW]; r = 1'b1; end
`endif
  endfunction

  function automatic void model_edge();
    int c;
    m_conf = 1'b0;
    for (int p = 0; p < NWR; p++)
      for (int q = p + 1; q < NWR; q++)
        if (wr_en[p] && wr_en[q] && wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW] && wr_addr[p*AW +: AW] != 0)
          m_conf = 1'b1;
    for (int p = 0; p < NWR; p++) begin
      int a = int'(wr_addr[p*AW +: AW]);
      if (wr_en[p] && a != 0) begin m_data[a] = wr_data[p*DW +: DW]; m_rdy[a] = 1'b1; end
    end
    for (int k = 0; k < NAL; k++) begin
      int a = int'(alloc_addr[k*AW +: AW]);
      if (alloc_en[k] && a != 0) m_rdy[a] = 1'b0;
    end
    c = 0;
    for (int i = 0; i < N; i++) c += int'(m_rdy[i]);
    m_cnt = c;
  endfunction

  task automatic check_all();
    logic [31:0] d;
    bit r;
    for (int k = 0; k < NRD; k++) begin
      model_read(int'(rd_addr[k*AW +: AW]), d, r);
      chk($sformatf("rd_data%0d@p%0d", k, rd_addr[k*AW +: AW]), 64'(rd_data[k*DW +: DW]), 64'(d));
      chk($sformatf("rd_rdy%0d@p%0d", k, rd_addr[k*AW +: AW]), 64'(rd_rdy[k]), 64'(r));
    end
    chk("wr_conflict", 64'(wr_conflict), 64'(m_conf));
    chk("rdy_count", 64'(rdy_count), 64'(m_cnt));
  endtask

  // Inputs are set at posedge+1; outputs compared at negedge; model advanced at posedge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; alloc_en = '0; alloc_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    set_rd(0, 1, 5, 63);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data", 64'(rd_data[63:0]) | 64'(rd_data[127:64]), 64'h0);
    chk("reset rd_rdy", 64'(rd_rdy), 64'hF);
    chk("reset rdy_count", 64'(rdy_count), 64'd64);
    chk("reset wr_conflict", 64'(wr_conflict), 64'h0);
    rstn = 1'b1;
    step();

    // Alloc p5, then write it.
    alloc_en = 2'b01; alloc_addr = {AW'(0), AW'(5)}; set_rd(5, 0, 0, 0);
    step();
    idle(); #1;
    chk("alloc p5 rdy", 64'(rd_rdy[0]), 64'h0);
    chk("alloc p5 count", 64'(rdy_count), 64'd63);
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {32'h0, 32'h1234}; #1;
`ifdef PRF_BYPASS_EN
    chk("bypass p5 data", 64'(rd_data[31:0]), 64'h1234);
    chk("bypass p5 rdy", 64'(rd_rdy[0]), 64'h1);
`else
    chk("nobypass p5 data", 64'(rd_data[31:0]), 64'h0);
    chk("nobypass p5 rdy", 64'(rd_rdy[0]), 64'h0);
`endif
    step();
    idle(); #1;
    chk("write p5 data", 64'(rd_data[31:0]), 64'h1234);
    chk("write p5 rdy", 64'(rd_rdy[0]), 64'h1);
    chk("write p5 count", 64'(rdy_count), 64'd64);

    // Two ports write p7 in the same cycle.
    wr_en = 2'b11; wr_addr = {AW'(7), AW'(7)}; wr_data = {32'hBBBB, 32'hAAAA}; set_rd(7, 0, 0, 0);
    step();
    idle(); #1;
    chk("conflict pulse", 64'(wr_conflict), 64'h1);
    chk("conflict p7 data", 64'(rd_data[31:0]), 64'hBBBB);
    step();
    chk("conflict cleared", 64'(wr_conflict), 64'h0);

    // p0 protection.
    alloc_en = 2'b10; alloc_addr = {AW'(0), AW'(3)}; wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'hFFFF};
    set_rd(0, 3, 0, 0); #1;
    chk("p0 data same cycle", 64'(rd_data[31:0]), 64'h0);
    step();
    idle(); #1;
    chk("p0 data", 64'(rd_data[31:0]), 64'h0);
    chk("p0 rdy", 64'(rd_rdy[0]), 64'h1);
    chk("p0 count", 64'(rdy_count), 64'd64);

    // Alloc and write race on p9.
    alloc_en = 2'b01; alloc_addr = {AW'(0), AW'(9)}; wr_en = 2'b10; wr_addr = {AW'(9), AW'(0)};
    wr_data = {32'h55, 32'h0}; set_rd(9, 0, 0, 0);
    step();
    idle(); #1;
    chk("race p9 rdy", 64'(rd_rdy[0]), 64'h0);
    chk("race p9 data", 64'(rd_data[31:0]), 64'h55);
    chk("race p9 count", 64'(rdy_count), 64'd63);
    step();

    // Random traffic on a narrow address window to provoke collisions and races.
    for (int c = 0; c < 400; c++) begin
      wr_en    = NWR'($urandom_range(0, 3));
      alloc_en = NAL'($urandom_range(0, 3));
      for (int p = 0; p < NWR; p++) begin
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, 15));
        wr_data[p*DW +: DW] = $urandom;
      end
      for (int k = 0; k < NAL; k++) alloc_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
      for (int k = 0; k < NRD; k++)
        rd_addr[k*AW +: AW] = (k == 3) ? AW'($urandom_range(0, N - 1)) : AW'($urandom_range(0, 15));
      step();
    end

    // Asynchronous reset mid-cycle with a pending write.
    idle();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(11)}; wr_data = {32'h0, 32'h77};
    alloc_en = 2'b01; alloc_addr = {AW'(0), AW'(12)};
    step();
    idle();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(11)}; wr_data = {32'h0, 32'h99}; set_rd(11, 12, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("async rst p11 data", 64'(rd_data[31:0]), 64'h0);
    chk("async rst p12 rdy", 64'(rd_rdy[1]), 64'h1);
    chk("async rst count", 64'(rdy_count), 64'd64);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle();
    #1;
    chk("post rst p11 data", 64'(rd_data[31:0]), 64'h0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
endmodule
